// File: rtl/irq_aggregator_8.sv
// Eight-line interrupt aggregator: synchronises, qualifies (edge/level), masks and latches
// each source, drives ext_irq and serves a claim/complete handshake to the core.
module irq_aggregator_8 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       irq_in0,
  input  logic       irq_in1,
  input  logic       irq_in2,
  input  logic       irq_in3,
  input  logic       irq_in4,
  input  logic       irq_in5,
  input  logic       irq_in6,
  input  logic       irq_in7,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  output logic [7:0] cfg_rdata,
  input  logic       claim_req,
  output logic       claim_ack,
  output logic       claim_valid,
  output logic [2:0] claim_id,
  input  logic       complete_req,
  input  logic [2:0] complete_id,
  output logic       ext_irq
);

  localparam logic [1:0] ADDR_ENABLE     = 2'd0;
  localparam logic [1:0] ADDR_MODE       = 2'd1;
  localparam logic [1:0] ADDR_PENDING    = 2'd2;
  localparam logic [1:0] ADDR_IN_SERVICE = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] raw_irq;
  logic [7:0] sync_irq;
  logic [7:0] prev_irq;
  logic [7:0] rise_irq;
  logic [7:0] enable_q;
  logic [7:0] mode_q;
  logic [7:0] pending_q;
  logic [7:0] in_service_q;
  logic [7:0] eligible;
  logic       any_eligible;
  logic [2:0] claim_idx;
  logic       claim_fire;
  logic [7:0] claim_mask;
  logic [7:0] complete_mask;
  logic [7:0] w1c_mask;
  logic [7:0] pending_nxt;
  logic [7:0] in_service_nxt;

  assign raw_irq = {irq_in7, irq_in6, irq_in5, irq_in4, irq_in3, irq_in2, irq_in1, irq_in0};

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_irq = raw_irq;
    end else begin : g_sync
      logic [7:0] stages [SYNC_STAGES];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < SYNC_STAGES; k++) begin
            stages[k] <= '0;
          end
        end else begin
          stages[0] <= raw_irq;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            stages[k] <= stages[k-1];
          end
        end
      end

      assign sync_irq = stages[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_irq <= '0;
    end else begin
      prev_irq <= sync_irq;
    end
  end

  assign rise_irq     = sync_irq & ~prev_irq;
  assign eligible     = pending_q & enable_q & ~in_service_q;
  assign any_eligible = |eligible;

  // Index 0 is highest priority, so scan downward and let the lowest set bit win.
  always_comb begin
    claim_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (eligible[i]) begin
        claim_idx = 3'(i);
      end
    end
  end

  assign claim_fire    = (state == IDLE) && claim_req;
  assign claim_mask    = (claim_fire && any_eligible) ? (8'd1 << claim_idx) : 8'd0;
  assign complete_mask = complete_req ? (8'd1 << complete_id) : 8'd0;
  assign w1c_mask      = (cfg_we && (cfg_addr == ADDR_PENDING)) ? cfg_wdata : 8'd0;

  // Edge lines: a fresh rising edge outranks any same-cycle clear; level lines simply follow.
  always_comb begin
    pending_nxt = (mode_q & (rise_irq | (pending_q & ~w1c_mask & ~claim_mask)))
                | (~mode_q & sync_irq);
  end

  // Claimed IDs are never in service, so a same-ID complete cannot undo a fresh claim.
  always_comb begin
    in_service_nxt = (in_service_q & ~complete_mask) | claim_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q     <= '0;
      mode_q       <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      ext_irq      <= 1'b0;
    end else begin
      if (cfg_we && (cfg_addr == ADDR_ENABLE)) begin
        enable_q <= cfg_wdata;
      end
      if (cfg_we && (cfg_addr == ADDR_MODE)) begin
        mode_q <= cfg_wdata;
      end
      pending_q    <= pending_nxt;
      in_service_q <= in_service_nxt;
      ext_irq      <= any_eligible;
    end
  end

  always_comb begin
    cfg_rdata = 8'd0;
    case (cfg_addr)
      ADDR_ENABLE:     cfg_rdata = enable_q;
      ADDR_MODE:       cfg_rdata = mode_q;
      ADDR_PENDING:    cfg_rdata = pending_q;
      ADDR_IN_SERVICE: cfg_rdata = in_service_q;
      default:         cfg_rdata = 8'd0;
    endcase
  end

  // claim_id/claim_valid persist after the ack pulse until the next claim overwrites them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      claim_ack   <= 1'b0;
      claim_valid <= 1'b0;
      claim_id    <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (claim_req) begin
            state       <= ACK;
            claim_ack   <= 1'b1;
            claim_valid <= any_eligible;
            claim_id    <= any_eligible ? claim_idx : 3'd0;
          end
        end
        ACK: begin
          state     <= IDLE;
          claim_ack <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          claim_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_aggregator_8.sv
// Directed bench for irq_aggregator_8: a level-mode priority vector table plus
// hand-written edge, mask, complete and collision sequences.
module tb_irq_aggregator_8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] cfg_rdata;
  logic       claim_req;
  logic       claim_ack;
  logic       claim_valid;
  logic [2:0] claim_id;
  logic       complete_req;
  logic [2:0] complete_id;
  logic       ext_irq;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [7:0] irq_pattern;
    logic [7:0] enable;
    logic       exp_ext;
    logic       exp_valid;
    logic [2:0] exp_id;
    logic [7:0] exp_insvc;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  irq_aggregator_8 #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .irq_in0      (irq[0]),
    .irq_in1      (irq[1]),
    .irq_in2      (irq[2]),
    .irq_in3      (irq[3]),
    .irq_in4      (irq[4]),
    .irq_in5      (irq[5]),
    .irq_in6      (irq[6]),
    .irq_in7      (irq[7]),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_rdata    (cfg_rdata),
    .claim_req    (claim_req),
    .claim_ack    (claim_ack),
    .claim_valid  (claim_valid),
    .claim_id     (claim_id),
    .complete_req (complete_req),
    .complete_id  (complete_id),
    .ext_irq      (ext_irq)
  );

  task tick;
    @(posedge clk);
    #1;
  endtask

  task checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
    end
  endtask

  task checkReg(input string name, input logic [1:0] addr, input logic [7:0] expected);
    cfg_addr = addr;
    #1;
    checkOutput(name, cfg_rdata, expected);
  endtask

  task cfgWrite(input logic [1:0] addr, input logic [7:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    tick();
    cfg_we    = 1'b0;
  endtask

  task doReset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Level mode, one vector per reset: pending follows the lines, then a single claim.
  task applyStimulus(input vec_t v, input int n);
    doReset();
    cfgWrite(2'd0, v.enable);
    irq = v.irq_pattern;
    repeat (4) tick();
    checkOutput($sformatf("vec%0d ext_irq", n), {7'd0, ext_irq}, {7'd0, v.exp_ext});
    checkReg($sformatf("vec%0d pending", n), 2'd2, v.irq_pattern);
    claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
    checkOutput($sformatf("vec%0d claim_ack", n), {7'd0, claim_ack}, 8'd1);
    checkOutput($sformatf("vec%0d claim_valid", n), {7'd0, claim_valid}, {7'd0, v.exp_valid});
    checkOutput($sformatf("vec%0d claim_id", n), {5'd0, claim_id}, {5'd0, v.exp_id});
    checkReg($sformatf("vec%0d in_service", n), 2'd3, v.exp_insvc);
    tick();
    irq = 8'd0;
  endtask

  initial begin
    vecs[0] = '{8'h88, 8'hFF, 1'b1, 1'b1, 3'd3, 8'h08};
    vecs[1] = '{8'h01, 8'hFF, 1'b1, 1'b1, 3'd0, 8'h01};
    vecs[2] = '{8'hF0, 8'h3F, 1'b1, 1'b1, 3'd4, 8'h10};
    vecs[3] = '{8'h80, 8'h80, 1'b1, 1'b1, 3'd7, 8'h80};
    vecs[4] = '{8'h55, 8'hAA, 1'b0, 1'b0, 3'd0, 8'h00};
    vecs[5] = '{8'h00, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00};
    vecs[6] = '{8'hFE, 8'hFC, 1'b1, 1'b1, 3'd2, 8'h04};
    vecs[7] = '{8'h60, 8'hFF, 1'b1, 1'b1, 3'd5, 8'h20};

    rst          = 1'b1;
    irq          = 8'hA5;
    cfg_we       = 1'b1;
    cfg_addr     = 2'd0;
    cfg_wdata    = 8'hFF;
    claim_req    = 1'b1;
    complete_req = 1'b1;
    complete_id  = 3'd5;

    // Reset held with busy inputs: nothing may leak through.
    tick();
    irq      = 8'h5A;
    cfg_addr = 2'd1;
    tick();
    cfg_we       = 1'b0;
    claim_req    = 1'b0;
    complete_req = 1'b0;
    irq          = 8'h00;
    checkOutput("reset ext_irq", {7'd0, ext_irq}, 8'd0);
    checkOutput("reset claim_ack", {7'd0, claim_ack}, 8'd0);
    checkOutput("reset claim_valid", {7'd0, claim_valid}, 8'd0);
    checkOutput("reset claim_id", {5'd0, claim_id}, 8'd0);
    for (int a = 0; a < 4; a++) begin
      checkReg($sformatf("reset reg%0d", a), 2'(a), 8'd0);
    end
    rst = 1'b0;

    for (int n = 0; n < 8; n++) begin
      applyStimulus(vecs[n], n);
    end

    // Edge on line 5 through the synchroniser, then claim.
    doReset();
    cfgWrite(2'd0, 8'hFF);
    cfgWrite(2'd1, 8'hFF);
    irq = 8'h20;
    tick();
    irq = 8'h00;
    tick();
    tick();
    checkReg("edge pending", 2'd2, 8'h20);
    checkOutput("edge ext_irq early", {7'd0, ext_irq}, 8'd0);
    tick();
    checkOutput("edge ext_irq rise", {7'd0, ext_irq}, 8'd1);
    claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
    checkOutput("edge claim_ack", {7'd0, claim_ack}, 8'd1);
    checkOutput("edge claim_id", {5'd0, claim_id}, 8'd5);
    checkOutput("edge claim_valid", {7'd0, claim_valid}, 8'd1);
    checkReg("edge in_service", 2'd3, 8'h20);
    checkReg("edge pending cleared", 2'd2, 8'h00);
    tick();
    checkOutput("edge ack drop", {7'd0, claim_ack}, 8'd0);
    checkOutput("edge ext_irq drop", {7'd0, ext_irq}, 8'd0);
    cfgWrite(2'd3, 8'h00);
    checkReg("in_service read-only", 2'd3, 8'h20);

    // Priority between two simultaneous edges, then an empty claim.
    doReset();
    cfgWrite(2'd0, 8'hFF);
    cfgWrite(2'd1, 8'hFF);
    irq = 8'h88;
    tick();
    irq = 8'h00;
    tick();
    tick();
    checkReg("prio pending", 2'd2, 8'h88);
    claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
    checkOutput("prio claim1 id", {5'd0, claim_id}, 8'd3);
    tick();
    checkOutput("prio ack one cycle", {7'd0, claim_ack}, 8'd0);
    checkOutput("prio id hold", {5'd0, claim_id}, 8'd3);
    claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
    checkOutput("prio claim2 id", {5'd0, claim_id}, 8'd7);
    checkOutput("prio claim2 valid", {7'd0, claim_valid}, 8'd1);
    tick();
    claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
    checkOutput("prio claim3 ack", {7'd0, claim_ack}, 8'd1);
    checkOutput("prio claim3 valid", {7'd0, claim_valid}, 8'd0);
    checkOutput("prio claim3 id", {5'd0, claim_id}, 8'd0);
    checkReg("prio in_service", 2'd3, 8'h88);
    tick();

    // Masked pending line becomes visible once enabled.
    doReset();
    cfgWrite(2'd1, 8'hFF);
    irq = 8'h04;
    tick();
    irq = 8'h00;
    tick();
    tick();
    tick();
    checkReg("mask pending", 2'd2, 8'h04);
    checkOutput("mask ext_irq off", {7'd0, ext_irq}, 8'd0);
    cfgWrite(2'd0, 8'h04);
    checkOutput("mask ext_irq latency", {7'd0, ext_irq}, 8'd0);
    tick();
    checkOutput("mask ext_irq on", {7'd0, ext_irq}, 8'd1);

    // Level line, claim and complete.
    doReset();
    cfgWrite(2'd0, 8'hFF);
    irq = 8'h02;
    repeat (4) tick();
    checkOutput("level ext_irq", {7'd0, ext_irq}, 8'd1);
    claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
    checkOutput("level claim_id", {5'd0, claim_id}, 8'd1);
    checkReg("level pending kept", 2'd2, 8'h02);
    tick();
    checkOutput("level ext_irq served", {7'd0, ext_irq}, 8'd0);
    complete_req = 1'b1;
    complete_id  = 3'd4;
    tick();
    complete_req = 1'b0;
    checkReg("stray complete ignored", 2'd3, 8'h02);
    complete_req = 1'b1;
    complete_id  = 3'd1;
    tick();
    complete_req = 1'b0;
    checkReg("level complete", 2'd3, 8'h00);
    checkOutput("level ext_irq still low", {7'd0, ext_irq}, 8'd0);
    tick();
    checkOutput("level ext_irq reassert", {7'd0, ext_irq}, 8'd1);
    irq = 8'h00;
    tick();
    tick();
    checkReg("level pending before sync", 2'd2, 8'h02);
    tick();
    checkReg("level pending dropped", 2'd2, 8'h00);

    // Same-cycle claim and complete: completed ID is not re-claimable.
    irq = 8'h0A;
    repeat (4) tick();
    claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
    checkOutput("combo claim1 id", {5'd0, claim_id}, 8'd1);
    tick();
    claim_req    = 1'b1;
    complete_req = 1'b1;
    complete_id  = 3'd1;
    tick();
    claim_req    = 1'b0;
    complete_req = 1'b0;
    checkOutput("combo claim2 id", {5'd0, claim_id}, 8'd3);
    checkReg("combo in_service", 2'd3, 8'h08);
    tick();
    irq = 8'h00;

    // Edge set collides with W1C of the same bit.
    doReset();
    cfgWrite(2'd1, 8'hFF);
    irq = 8'h10;
    tick();
    irq = 8'h00;
    tick();
    cfgWrite(2'd2, 8'h10);
    checkReg("collide set wins", 2'd2, 8'h10);
    cfgWrite(2'd2, 8'h10);
    checkReg("w1c clears", 2'd2, 8'h00);

    // Reset during the ACK cycle.
    cfgWrite(2'd0, 8'hFF);
    irq = 8'h40;
    tick();
    irq = 8'h00;
    repeat (3) tick();
    claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
    checkOutput("abort claim_ack", {7'd0, claim_ack}, 8'd1);
    checkOutput("abort claim_id", {5'd0, claim_id}, 8'd6);
    rst = 1'b1;
    tick();
    checkOutput("abort ack cleared", {7'd0, claim_ack}, 8'd0);
    checkOutput("abort valid cleared", {7'd0, claim_valid}, 8'd0);
    checkOutput("abort id cleared", {5'd0, claim_id}, 8'd0);
    checkOutput("abort ext_irq", {7'd0, ext_irq}, 8'd0);
    for (int a = 0; a < 4; a++) begin
      checkReg($sformatf("abort reg%0d", a), 2'(a), 8'd0);
    end
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
